// File: rtl/trap_peak_sequencer.sv
`timescale 1ns/1ps
// trap_peak_sequencer
// Control block that follows a trapezoidal shaping filter (rise K, flat-top
// end L). On enable it flushes the filter delay lines, arms a threshold
// trigger, samples the trapezoid at mid flat-top, flags pile-up inside the
// pulse window and hands amplitude + timestamp to a valid/ready register.
// Optional build macro: TRAP_PILEUP_REJECT_EN (drop pile-up results instead
// of emitting them flagged).
module trap_peak_sequencer #(
   parameter int FILT_W   = 24,
   parameter int K        = 5,
   parameter int L        = 8,
   parameter int SIZE_CNT = 4,
   parameter int TS_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [FILT_W-1:0] thr,
   input  logic              filt_valid,
   input  logic [FILT_W-1:0] filt_data,
   output logic              filt_clr,
   output logic              busy,
   output logic              peak_valid,
   input  logic              peak_ready,
   output logic [FILT_W-1:0] peak_amp,
   output logic [TS_W-1:0]   peak_ts,
   output logic              peak_pileup,
   output logic [7:0]        drop_cnt
);

   // Window and flush lengths must fit the shared counter.
   if (K >= L || (K + L) > ((1 << SIZE_CNT) - 1)) begin : g_param_check
      $error("trap_peak_sequencer: need K < L and K+L <= 2**SIZE_CNT-1");
   end

   // Last count of the flush and of the pulse window (both K+L long).
   localparam logic [SIZE_CNT-1:0] LAST_CNT  = SIZE_CNT'(K + L - 1);
   // Count at which the rise is complete and the flat top begins.
   localparam logic [SIZE_CNT-1:0] RISE_LAST = SIZE_CNT'(K - 1);
   // Mid flat-top sample: the amplitude is taken here.
   localparam logic [SIZE_CNT-1:0] AMP_CNT   = SIZE_CNT'(K + (L - K) / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_ARM,
      S_RISE,
      S_FLAT,
      S_EMIT,
      S_QUIET
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [SIZE_CNT-1:0] cnt;
   logic [TS_W-1:0]     ts;
   logic                below;
   logic [FILT_W-1:0]   pend_amp;
   logic [TS_W-1:0]     pend_ts;
   logic                pend_pileup;

   logic ge_thr;
   logic in_window;
   logic out_free;
   logic emit_ok;
   logic trig;
   logic recross;
   logic emit_load;
   logic emit_drop;

   assign ge_thr    = $signed(filt_data) >= $signed(thr);
   assign in_window = (state == S_RISE) || (state == S_FLAT);
   assign out_free  = !peak_valid || peak_ready;
   assign busy      = (state != S_IDLE) && (state != S_ARM);

`ifdef TRAP_PILEUP_REJECT_EN
   assign emit_ok     = out_free && !pend_pileup;
   assign peak_pileup = 1'b0;
`else
   assign emit_ok     = out_free;
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: every register in a clocked block is written with <= so all
      // flops update from the same pre-edge values, whatever the statement order.
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      // NOTE: each signal gets a default before the case so no path leaves it
      // unassigned; a missing default would infer a latch.
      state_nxt = state;
      filt_clr  = 1'b0;
      trig      = 1'b0;
      recross   = 1'b0;
      emit_load = 1'b0;
      emit_drop = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            filt_clr = 1'b1;
            if (cnt == LAST_CNT) state_nxt = S_ARM;
         end
         S_ARM: begin
            if (filt_valid && ge_thr && below) begin
               trig      = 1'b1;
               state_nxt = S_RISE;
            end
         end
         S_RISE, S_FLAT: begin
            if (filt_valid) begin
               recross = ge_thr && below && (cnt != '0);
               if (cnt == LAST_CNT)                          state_nxt = S_EMIT;
               else if (state == S_RISE && cnt >= RISE_LAST) state_nxt = S_FLAT;
            end
         end
         S_EMIT: begin
            state_nxt = S_QUIET;
            if (emit_ok) emit_load = 1'b1;
            else         emit_drop = 1'b1;
         end
         S_QUIET: begin
            if (filt_valid && !ge_thr) state_nxt = S_ARM;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Dropping enable aborts everything in flight, including a pending emit.
      if (!en) begin
         state_nxt = S_IDLE;
         filt_clr  = 1'b0;
         trig      = 1'b0;
         recross   = 1'b0;
         emit_load = 1'b0;
         emit_drop = 1'b0;
      end
   end

   // Counters, trigger bookkeeping, pending capture and the output register.
   always_ff @(posedge clk) begin
      // NOTE: the pending capture registers are reset as well, so a reset
      // mid-window leaves no stale amplitude or timestamp behind.
      if (!reset_n) begin
         ts          <= '0;
         cnt         <= '0;
         below       <= 1'b1;
         pend_amp    <= '0;
         pend_ts     <= '0;
         pend_pileup <= 1'b0;
         peak_valid  <= 1'b0;
         peak_amp    <= '0;
         peak_ts     <= '0;
`ifndef TRAP_PILEUP_REJECT_EN
         peak_pileup <= 1'b0;
`endif
         drop_cnt    <= '0;
      end else begin
         if (state == S_IDLE)        ts <= '0;
         else if (en && filt_valid)  ts <= ts + 1'b1;

         if (!en || state == S_IDLE)     cnt <= '0;
         else if (state == S_FLUSH)      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
         else if (trig)                  cnt <= SIZE_CNT'(1);
         else if (in_window && filt_valid) cnt <= cnt + 1'b1;

         // The filter output is meaningless while its delay lines are cleared.
         if (filt_valid && state != S_FLUSH) begin
            if (!ge_thr)              below <= 1'b1;
            else if (trig || recross) below <= 1'b0;
         end

         if (trig) begin
            pend_ts     <= ts;
            pend_pileup <= 1'b0;
         end else if (recross) begin
            pend_pileup <= 1'b1;
         end

         if (en && in_window && filt_valid && cnt == AMP_CNT) pend_amp <= filt_data;

         if (emit_load) begin
            peak_valid  <= 1'b1;
            peak_amp    <= pend_amp;
            peak_ts     <= pend_ts;
`ifndef TRAP_PILEUP_REJECT_EN
            peak_pileup <= pend_pileup;
`endif
         end else if (peak_valid && peak_ready) begin
            peak_valid <= 1'b0;
         end

         if (emit_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule
